// File: rtl/lampfpu_sqrtround_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lampfpu_sqrtround_pkg: shared types/rounding helper for sqrt rounding   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
package lampfpu_sqrtround_pkg;

   localparam int SQRT_F_W = 12;

   // Infinity exponent and fraction fields of a bfloat16, sign excluded
   localparam logic [14:0] INF_E_F = {8'hFF, 7'h00};

   typedef struct packed {
      logic                s;
      logic [7:0]          e;
      logic [SQRT_F_W-1:0] f;
      logic                is_to_round;
   } sqrt_res_t;

   typedef struct packed {
      logic [15:0] res;
      logic        inexact;
   } out_entry_t;

   // Round-to-nearest-even on {headroom, hidden, frac[6:0]}; returns {m[9:0], inexact}
   function automatic logic [10:0] round_rne(input logic [SQRT_F_W-1:0] f);
      logic       lsb;
      logic       g;
      logic       rs;
      logic       rnd;
      logic [9:0] m;
      lsb = f[3];
      g   = f[2];
      rs  = f[1] | f[0];
      rnd = g & (rs | lsb);
      m   = {1'b0, f[11:3]} + {9'd0, rnd};
      return {m, g | rs};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lampfpu_sqrtround_fifo.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lampfpu_sqrtround_fifo: synchronous FIFO, push/pop/full/empty/count     |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module lampfpu_sqrtround_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 17
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [CNT_W-1:0] cnt_t;

   logic [WIDTH-1:0] mem [DEPTH];
   ptr_t             wr_ptr;
   ptr_t             rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == cnt_t'(DEPTH));
   assign do_pop  = pop & ~empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + ptr_t'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + ptr_t'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + cnt_t'(1);
            2'b01:   count <= count - cnt_t'(1);
            default: count <= count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/lampfpu_sqrtround.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | lampfpu_sqrtround: RNE rounding, renormalise and bfloat16 pack + FIFO   |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module lampfpu_sqrtround
   import lampfpu_sqrtround_pkg::*;
#(
   parameter int FIFO_DEPTH = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_i,
   input  logic                s_i,
   input  logic [7:0]          e_i,
   input  logic [SQRT_F_W-1:0] f_i,
   input  logic                isToRound_i,
   input  logic                ready_i,
   input  logic                clearOvf_i,
   output logic                valid_o,
   output logic [15:0]         res_o,
   output logic                inexact_o,
   output logic                busy_o,
   output logic                ovf_o
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   typedef logic [CNT_W:0] occ_t;

   sqrt_res_t        in_op;
   logic [9:0]       rnd_m;
   logic             rnd_inexact;

   logic             r1_valid;
   logic             r1_s;
   logic [7:0]       r1_e;
   logic [9:0]       r1_m;
   logic             r1_inexact;
   logic             r1_is_round;
   logic [6:0]       r1_fspec;

   logic             shift;
   logic [7:0]       exp_adj;
   out_entry_t       wr_entry;
   out_entry_t       head;

   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             pop_ok;
   logic             push_ok;
   logic             drop;
   occ_t             occ_nxt;

   assign in_op = '{s: s_i, e: e_i, f: f_i, is_to_round: isToRound_i};
   assign {rnd_m, rnd_inexact} = round_rne(in_op.f);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r1_valid    <= 1'b0;
         r1_s        <= 1'b0;
         r1_e        <= '0;
         r1_m        <= '0;
         r1_inexact  <= 1'b0;
         r1_is_round <= 1'b0;
         r1_fspec    <= '0;
      end else begin
         r1_valid <= valid_i;
         if (valid_i) begin
            r1_s        <= in_op.s;
            r1_e        <= in_op.e;
            r1_m        <= rnd_m;
            r1_inexact  <= rnd_inexact;
            r1_is_round <= in_op.is_to_round;
            r1_fspec    <= in_op.f[11:5];
         end
      end
   end

   // A set bit above the hidden position means the value reached 2.0
   always_comb begin
      shift    = r1_m[9] | r1_m[8];
      exp_adj  = r1_e + {7'd0, shift};
      wr_entry = '0;
      if (!r1_is_round) begin
         wr_entry.res     = {r1_s, r1_e, r1_fspec};
         wr_entry.inexact = 1'b0;
      end else if (exp_adj == 8'hFF) begin
         wr_entry.res     = {r1_s, INF_E_F};
         wr_entry.inexact = r1_inexact;
      end else begin
         wr_entry.res     = {r1_s, exp_adj, (shift ? r1_m[7:1] : r1_m[6:0])};
         wr_entry.inexact = r1_inexact;
      end
   end

   lampfpu_sqrtround_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH ($bits(out_entry_t))
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (r1_valid),
      .pop   (pop_ok),
      .din   (wr_entry),
      .dout  (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign valid_o   = ~fifo_empty;
   assign pop_ok    = valid_o & ready_i;
   assign push_ok   = r1_valid & (~fifo_full | pop_ok);
   assign drop      = r1_valid & fifo_full & ~pop_ok;
   assign res_o     = valid_o ? head.res : 16'h0000;
   assign inexact_o = valid_o & head.inexact;

   // Occupancy as it will stand after this edge: FIFO entries plus the R1 slot
   assign occ_nxt = occ_t'(fifo_count) + occ_t'(push_ok) - occ_t'(pop_ok) + occ_t'(valid_i);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_o <= 1'b0;
         ovf_o  <= 1'b0;
      end else begin
         busy_o <= (occ_nxt >= occ_t'(FIFO_DEPTH - 1));
         if (drop) begin
            ovf_o <= 1'b1;
         end else if (clearOvf_i) begin
            ovf_o <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lampfpu_sqrtround.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_lampfpu_sqrtround: scoreboard bench for the sqrt rounding stage      |
// | Revision: 1.0                                                           |
// +------------------------------------------------------------------------+
module tb_lampfpu_sqrtround;

   localparam int FIFO_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid_i = 1'b0;
   logic        s_i = 1'b0;
   logic [7:0]  e_i = '0;
   logic [11:0] f_i = '0;
   logic        isToRound_i = 1'b0;
   logic        ready_i = 1'b0;
   logic        clearOvf_i = 1'b0;
   logic        valid_o;
   logic [15:0] res_o;
   logic        inexact_o;
   logic        busy_o;
   logic        ovf_o;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [16:0] exp_q[$];
   logic [15:0] held_res;
   logic        held_v = 1'b0;

   always #5 clk = ~clk;

   lampfpu_sqrtround #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_i     (valid_i),
      .s_i         (s_i),
      .e_i         (e_i),
      .f_i         (f_i),
      .isToRound_i (isToRound_i),
      .ready_i     (ready_i),
      .clearOvf_i  (clearOvf_i),
      .valid_o     (valid_o),
      .res_o       (res_o),
      .inexact_o   (inexact_o),
      .busy_o      (busy_o),
      .ovf_o       (ovf_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      if (obs !== expv) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // Reference: integer rounding on the 1/8-ulp remainder; returns {res, inexact}
   function automatic logic [16:0] model(input logic s, input logic [7:0] e,
                                         input logic [11:0] f, input logic isr);
      int   mant;
      int   rem;
      int   ee;
      logic up;
      if (!isr) return {s, e, f[11:5], 1'b0};
      mant = int'(f >> 3);
      rem  = int'(f & 12'h007);
      up   = (rem > 4) || (rem == 4 && (mant % 2) == 1);
      mant = mant + int'(up);
      ee   = int'(e);
      if (mant >= 256) begin
         mant = mant / 2;
         ee   = ee + 1;
      end
      if (ee >= 255) return {s, 8'hFF, 7'h00, rem != 0};
      return {s, ee[7:0], mant[6:0], rem != 0};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [7:0] e, input logic [11:0] f,
                        input logic isr, input logic expect_out);
      s_i = s; e_i = e; f_i = f; isToRound_i = isr; valid_i = 1'b1;
      if (expect_out) exp_q.push_back(model(s, e, f, isr));
      tick();
      valid_i = 1'b0;
   endtask

   task automatic drain(input string tag);
      int cyc;
      cyc = 0;
      ready_i = 1'b1;
      while (exp_q.size() != 0 && cyc < 100) begin
         tick();
         cyc++;
      end
      check(tag, exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, valid_o, 0);
      check({tag, "_res"}, res_o, 0);
      check({tag, "_inexact"}, inexact_o, 0);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_ovf"}, ovf_o, 0);
   endtask

   // Inputs change just after posedge, so negedge values are what the next edge sees
   always @(negedge clk) begin
      logic [16:0] e;
      if (!rst) begin
         held_v = 1'b0;
      end else begin
         if (valid_o && !ready_i) begin
            if (held_v) check("hold_res", res_o, held_res);
            held_res = res_o;
            held_v   = 1'b1;
         end else begin
            held_v = 1'b0;
         end
         if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", valid_o, 0);
            end else begin
               e = exp_q.pop_front();
               check("res", res_o, e[16:1]);
               check("inexact", inexact_o, e[0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b1;
      ready_i = 1'b1;

      // First edge after release accepts; valid_o appears two edges later
      drive(1'b0, 8'h7F, 12'h400, 1'b1, 1'b1);
      check("lat_n1_valid", valid_o, 0);
      tick();
      check("lat_n2_valid", valid_o, 1);
      check("exact_res", res_o, 16'h3F80);
      check("exact_inexact", inexact_o, 0);
      drain("drain_exact");

      // Back-to-back directed corner cases at full throughput
      drive(1'b0, 8'h7F, 12'h404, 1'b1, 1'b1);
      drive(1'b0, 8'h7F, 12'h40C, 1'b1, 1'b1);
      drive(1'b0, 8'h80, 12'h7FC, 1'b1, 1'b1);
      drive(1'b0, 8'hFE, 12'h7FC, 1'b1, 1'b1);
      drive(1'b1, 8'h70, 12'h7FF, 1'b1, 1'b1);
      drive(1'b0, 8'hFF, 12'h800, 1'b0, 1'b1);
      for (int i = 0; i < 40; i++) begin
         drive(1'($urandom), 8'($urandom_range(0, 254)), 12'($urandom_range(12'h400, 12'hFFF)),
               1'($urandom_range(0, 3) != 0), 1'b1);
      end
      drain("drain_stream");

      // Random backpressure, issuing only when the busy hint allows
      for (int i = 0; i < 80; i++) begin
         ready_i = 1'($urandom_range(0, 1));
         if (!busy_o && $urandom_range(0, 1) == 1) begin
            drive(1'($urandom), 8'($urandom_range(0, 254)), 12'($urandom_range(12'h400, 12'h7FF)),
                  1'b1, 1'b1);
         end else begin
            tick();
         end
      end
      drain("drain_random");
      tick();
      check("ovf_after_random", ovf_o, 0);

      // Three results into a stalled two-entry buffer: third is dropped
      ready_i = 1'b0;
      drive(1'b0, 8'h10, 12'h500, 1'b1, 1'b1);
      drive(1'b1, 8'h20, 12'h600, 1'b1, 1'b1);
      check("bp_busy", busy_o, 1);
      drive(1'b0, 8'h30, 12'h700, 1'b1, 1'b0);
      tick();
      check("bp_ovf_set", ovf_o, 1);
      check("bp_valid", valid_o, 1);
      clearOvf_i = 1'b1;
      tick();
      clearOvf_i = 1'b0;
      check("bp_ovf_clear", ovf_o, 0);
      drain("drain_bp");
      repeat (2) tick();
      check("bp_no_third", valid_o, 0);
      check("bp_busy_low", busy_o, 0);

      // A drop coinciding with a clear keeps the flag set
      ready_i = 1'b0;
      drive(1'b0, 8'h40, 12'h480, 1'b1, 1'b1);
      drive(1'b0, 8'h41, 12'h490, 1'b1, 1'b1);
      drive(1'b0, 8'h42, 12'h4A0, 1'b1, 1'b0);
      clearOvf_i = 1'b1;
      tick();
      clearOvf_i = 1'b0;
      check("drop_wins_ovf", ovf_o, 1);
      clearOvf_i = 1'b1;
      tick();
      clearOvf_i = 1'b0;
      check("clear_ovf", ovf_o, 0);
      drain("drain_drop_wins");

      // Asynchronous reset with two entries queued
      ready_i = 1'b0;
      drive(1'b1, 8'h55, 12'h4C4, 1'b1, 1'b1);
      drive(1'b0, 8'h56, 12'h4C8, 1'b1, 1'b1);
      tick();
      check("pre_reset_valid", valid_o, 1);
      #3;
      rst = 1'b0;
      #1;
      check_all_zero("midreset");
      exp_q.delete();
      tick();
      rst = 1'b1;
      ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("no_stale_valid", valid_o, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lampfpu_sqrtround.md
# lampFPU_sqrtRound

Rounding and packing stage that sits directly downstream of the square-root unit (`lampFPU_sqrt`). It consumes that unit's registered sign, exponent, extended significand and `isToRound` flag. It applies round-to-nearest-even, renormalises on carry-out and packs a 16-bit bfloat result. A 2-entry output FIFO with valid/ready lets the FPU writeback tolerate backpressure, and a `busy_o` hint throttles issue of new square roots.

## Interface
Parameters:
- `FIFO_DEPTH`, default 2: output buffer entries; power of two, ≥2.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `valid_i`  in  1  upstream result valid, one-cycle pulse per result.
- `s_i`  in  1  sign.
- `e_i`  in  8  biased exponent.
- `f_i`  in  12  significand:
  - [11] overflow headroom, [10] hidden bit, [9:3] fraction, [2] guard, [1] round, [0] sticky.
  - Special values carry the fraction in [11:5].
- `isToRound_i`  in  1  1 = rounding path; 0 = special value, pass through.
- `ready_i`  in  1  downstream accepts the head entry.
- `clearOvf_i`  in  1  clears `ovf_o`.
- `valid_o`  out  1  head entry valid.
- `res_o`  out  16  packed {sign, exp[7:0], frac[6:0]}.
- `inexact_o`  out  1  head entry lost nonzero guard/round/sticky bits.
- `busy_o`  out  1  upstream must not issue a new sqrt.
- `ovf_o`  out  1  sticky: a result was dropped because the FIFO was full.

## Operation
- Stage R1 (registered on `valid_i`) computes:
  - `lsb=f_i[3]`, `g=f_i[2]`, `rs=f_i[1]|f_i[0]`.
  - `rnd = g & (rs|lsb)`.
  - `m[9:0] = {1'b0,f_i[11:3]} + rnd`.
  - `inexact = g|rs`.
- Stage R2 (combinational into the FIFO write):
  - If `m[9]`, or `m[8]` with headroom set: shift right 1, `exp = e_i+1`.
  - If the resulting `exp` is 255: emit Inf, i.e. exponent 8'hFF, fraction 0, sign kept.
  - Otherwise fraction is `m[6:0]` after normalisation.
  - `isToRound_i=0`: `res = {s_i, e_i, f_i[11:5]}`, `inexact=0`.
- FIFO push happens on R1 valid.
  - Pop when `valid_o & ready_i`.
  - Push and pop in the same cycle are both legal, including when full (count unchanged) and when empty (the new entry becomes the head next cycle, with no bypass).
- Occupancy for `busy_o` is the FIFO count plus the R1 valid bit. Assert `busy_o` when occupancy ≥ `FIFO_DEPTH-1`.
- Push while full with no pop: the entry is dropped, `ovf_o` is set and the FIFO contents are unchanged.
- `clearOvf_i` clears `ovf_o`. A drop in the same cycle wins, so `ovf_o` stays 1.

## Timing
- Reset (`rst` low, asynchronous) drives these to 0: `valid_o`, `res_o`, `inexact_o`, `busy_o`, `ovf_o`, the R1 valid bit, the FIFO count and the pointers. All in-flight data is discarded.
- Latency: `valid_i` at edge N gives R1 at N+1, FIFO write at N+1 and `valid_o` at N+2 if the FIFO was empty. Zero-wait throughput is 1 result per cycle.
- `res_o` and `inexact_o` are stable while `valid_o & ~ready_i`.
- `busy_o` is registered and reflects occupancy after edge N. Upstream samples it before asserting `doSqrt`, and the sqrt latency covers the remaining slot.
- `rst` deasserts synchronously to `clk` (external synchroniser). The first `valid_i` is accepted at the first edge after release.

## Structure
- Add to `lampFPU_pkg`:
  - `FUNC_roundRNE(f_i)` returning {m, inexact}.
  - Constant `SQRT_F_W=12`.
  - Typedef `sqrtRes_t` = {s, e[7:0], f[11:0], isToRound}.
  - Reuse the existing `INF_E_F`.
- Sub-module `lampFPU_fifo2`: a parameterised synchronous FIFO with push/pop/full/empty/count, asynchronous active-low reset, and its own unit test.

## Test plan
- Exact: `s=0, e=8'h7F, f=12'h400`, `ready_i=1` → `res_o=16'h3F80` at N+2, `inexact_o=0`.
- Tie to even: `f=12'h404` (lsb 0, g 1) → fraction 0, `inexact_o=1`. `f=12'h40C` (lsb 1) → fraction 7'h02.
- Carry-out: `e=8'h80, f=12'h7FC` → `res_o=16'h4080`. With `e=8'hFE` → `res_o=16'h7F80`.
- Special pass-through: `isToRound_i=0, e=8'hFF, f=12'h800` → `res_o=16'h7FC0`.
- Backpressure: `ready_i=0`, 3 back-to-back `valid_i`:
  - `busy_o` rises by N+2.
  - The third result is dropped and `ovf_o=1`.
  - Releasing `ready_i` yields the first two results in order.
  - `clearOvf_i` clears `ovf_o`.
- Reset mid-stream: `rst` pulled low with 2 entries queued → all outputs go to 0 immediately; after release no stale `valid_o`.
